// File: rtl/bru_if.sv
// Request/result bundle between the issue stage and the branch resolve unit (bru).
interface bru_if #(
  parameter int XLEN = 32
);
  logic            in_valid;
  logic            jump;
  logic            jalr;
  logic            branch;
  logic [2:0]      funct3;
  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] rs1_data;
  logic [XLEN-1:0] rs2_data;
  logic [XLEN-1:0] imm;
  logic            in_pred_taken;
  logic            flush;
  logic [XLEN-1:0] lookup_pc;
  logic            lookup_taken;
  logic            out_valid;
  logic            je;
  logic [XLEN-1:0] target;
  logic [XLEN-1:0] link;
  logic            mispredict;
  logic [31:0]     perf_branches;
  logic [31:0]     perf_mispredicts;

  modport master (
    output in_valid, jump, jalr, branch, funct3, pc, rs1_data, rs2_data, imm,
           in_pred_taken, flush, lookup_pc,
    input  lookup_taken, out_valid, je, target, link, mispredict,
           perf_branches, perf_mispredicts
  );

  modport slave (
    input  in_valid, jump, jalr, branch, funct3, pc, rs1_data, rs2_data, imm,
           in_pred_taken, flush, lookup_pc,
    output lookup_taken, out_valid, je, target, link, mispredict,
           perf_branches, perf_mispredicts
  );
endinterface

// File: rtl/bru.sv
// Branch resolve unit: resolves jumps/branches with a one-cycle registered result and
// trains a 2-bit-counter BHT. Define BRU_PERF_CNT_EN to add saturating event counters.
module bru #(
  parameter int XLEN      = 32,
  parameter int BHT_DEPTH = 64
) (
  input logic clk,
  input logic rst_n,
  bru_if.slave bus
);
  localparam int IW = $clog2(BHT_DEPTH);

  logic            acc, cond, je_d, upd;
  logic [XLEN-1:0] link_d, tgt_d, jalr_sum;
  logic [IW-1:0]   up_idx, lk_idx;
  logic [1:0]      ctr, ctr_d;
  logic [BHT_DEPTH-1:0][1:0] bht_q;
  logic            vld_q, je_q, misp_q;
  logic [XLEN-1:0] target_q, link_q;

  assign acc = bus.in_valid & ~bus.flush;

  always_comb begin
    cond = 1'b0;
    case (bus.funct3)
      3'b000:  cond = (bus.rs1_data == bus.rs2_data);
      3'b001:  cond = (bus.rs1_data != bus.rs2_data);
      3'b100:  cond = ($signed(bus.rs1_data) <  $signed(bus.rs2_data));
      3'b101:  cond = ($signed(bus.rs1_data) >= $signed(bus.rs2_data));
      3'b110:  cond = (bus.rs1_data <  bus.rs2_data);
      3'b111:  cond = (bus.rs1_data >= bus.rs2_data);
      default: cond = 1'b0;
    endcase
  end

  // Jump overrides any branch condition.
  assign je_d     = bus.jump | (bus.branch & cond);
  assign link_d   = bus.pc + XLEN'(4);
  assign jalr_sum = bus.rs1_data + bus.imm;

  always_comb begin
    tgt_d = link_d;
    if (je_d) tgt_d = (bus.jump & bus.jalr) ? {jalr_sum[XLEN-1:1], 1'b0}
                                            : bus.pc + bus.imm;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q    <= 1'b0;
      je_q     <= 1'b0;
      misp_q   <= 1'b0;
      target_q <= '0;
      link_q   <= '0;
    end else begin
      vld_q  <= acc;
      je_q   <= acc & je_d;
      misp_q <= acc & (je_d ^ bus.in_pred_taken);
      if (acc) begin
        target_q <= tgt_d;
        link_q   <= link_d;
      end
    end
  end

  assign bus.out_valid  = vld_q;
  assign bus.je         = je_q;
  assign bus.mispredict = misp_q;
  assign bus.target     = target_q;
  assign bus.link       = link_q;

  // BHT: lookup reads the registered array, so a same-cycle update is seen next cycle.
  assign lk_idx           = bus.lookup_pc[IW+1:2];
  assign up_idx           = bus.pc[IW+1:2];
  assign bus.lookup_taken = bht_q[lk_idx][1];
  assign upd              = acc & bus.branch & ~bus.jump;
  assign ctr              = bht_q[up_idx];

  always_comb begin
    if (cond) ctr_d = (ctr == 2'b11) ? ctr : ctr + 2'd1;
    else      ctr_d = (ctr == 2'b00) ? ctr : ctr - 2'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   bht_q <= {BHT_DEPTH{2'b01}};
    else if (upd) bht_q[up_idx] <= ctr_d;
  end

`ifdef BRU_PERF_CNT_EN
  logic [31:0] br_cnt_q, mp_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      br_cnt_q <= '0;
      mp_cnt_q <= '0;
    end else begin
      if (upd & ~&br_cnt_q) br_cnt_q <= br_cnt_q + 32'd1;
      if (acc & (je_d ^ bus.in_pred_taken) & ~&mp_cnt_q) mp_cnt_q <= mp_cnt_q + 32'd1;
    end
  end

  assign bus.perf_branches    = br_cnt_q;
  assign bus.perf_mispredicts = mp_cnt_q;
`else
  assign bus.perf_branches    = '0;
  assign bus.perf_mispredicts = '0;
`endif
endmodule

// File: tb/tb_bru.sv
// Self-checking bench for bru: directed scenarios plus random requests against a
// behavioural model (condition rules, target rules, BHT counters, perf counts).
module tb_bru;
  localparam int XLEN  = 32;
  localparam int DEPTH = 64;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  bru_if #(.XLEN(XLEN)) bif();
  bru #(.XLEN(XLEN), .BHT_DEPTH(DEPTH)) dut (.clk(clk), .rst_n(rst_n), .bus(bif.slave));

  int n_chk = 0, n_fail = 0;
  int bht_m [DEPTH];
  longint perf_br = 0, perf_mp = 0;
  bit p_acc, p_je, p_misp, p_upd;
  logic [31:0] p_tgt, p_link;
  int p_idx, l_idx;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic int idx_of(input logic [31:0] a);
    return int'((a >> 2) % DEPTH);
  endfunction

  function automatic longint exp_perf(input longint v);
`ifdef BRU_PERF_CNT_EN
    return v;
`else
    return 0 * v;
`endif
  endfunction

  task automatic set_req(input bit v, input bit fl, input bit jmp, input bit jr, input bit br,
                         input bit [2:0] f3, input logic [31:0] pc, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] imm, input bit pred,
                         input logic [31:0] lpc);
    bit c;
    bif.in_valid = v; bif.flush = fl; bif.jump = jmp; bif.jalr = jr; bif.branch = br;
    bif.funct3 = f3; bif.pc = pc; bif.rs1_data = a; bif.rs2_data = b; bif.imm = imm;
    bif.in_pred_taken = pred; bif.lookup_pc = lpc;
    case (f3)
      3'd0: c = (a == b);
      3'd1: c = (a != b);
      3'd4: c = ($signed(a) <  $signed(b));
      3'd5: c = ($signed(a) >= $signed(b));
      3'd6: c = (a <  b);
      3'd7: c = (a >= b);
      default: c = 1'b0;
    endcase
    p_je   = jmp || (br && c);
    p_acc  = v && !fl;
    p_link = pc + 32'd4;
    if (!p_je)          p_tgt = pc + 32'd4;
    else if (jmp && jr) p_tgt = (a + imm) & 32'hFFFF_FFFE;
    else                p_tgt = pc + imm;
    p_misp = p_je ^ pred;
    p_upd  = p_acc && br && !jmp;
    p_idx  = idx_of(pc);
    l_idx  = idx_of(lpc);
  endtask

  task automatic idle(input logic [31:0] lpc);
    set_req(0, 0, 0, 0, 0, 3'd0, 32'h0, 32'h0, 32'h0, 32'h0, 0, lpc);
  endtask

  // One cycle: check the combinational lookup, clock the request, then check results.
  task automatic tick();
    #1 chk("lookup_taken", bif.lookup_taken, (bht_m[l_idx] >> 1) & 1);
    @(posedge clk); #1;
    if (p_upd) begin
      bht_m[p_idx] = p_je ? ((bht_m[p_idx] < 3) ? bht_m[p_idx] + 1 : 3)
                          : ((bht_m[p_idx] > 0) ? bht_m[p_idx] - 1 : 0);
      if (perf_br < 64'hFFFF_FFFF) perf_br++;
    end
    if (p_acc && p_misp && perf_mp < 64'hFFFF_FFFF) perf_mp++;
    chk("out_valid", bif.out_valid, p_acc);
    if (p_acc) begin
      chk("je", bif.je, p_je);
      chk("target", bif.target, p_tgt);
      chk("link", bif.link, p_link);
    end
    chk("mispredict", bif.mispredict, p_acc & p_misp);
    chk("perf_branches", bif.perf_branches, exp_perf(perf_br));
    chk("perf_mispredicts", bif.perf_mispredicts, exp_perf(perf_mp));
  endtask

  task automatic do_reset();
    #2 rst_n = 1'b0;
    idle(32'h40);
    #1;
    chk("rst_out_valid", bif.out_valid, 0);
    chk("rst_je", bif.je, 0);
    chk("rst_mispredict", bif.mispredict, 0);
    chk("rst_target", bif.target, 0);
    chk("rst_link", bif.link, 0);
    chk("rst_perf_br", bif.perf_branches, 0);
    chk("rst_perf_mp", bif.perf_mispredicts, 0);
    chk("rst_lookup", bif.lookup_taken, 0);
    foreach (bht_m[i]) bht_m[i] = 1;
    perf_br = 0;
    perf_mp = 0;
    @(posedge clk); #3 rst_n = 1'b1;
  endtask

  initial begin
    bit exp_lk [4] = '{0, 1, 1, 1};
    logic [31:0] pc, a, b;
    do_reset();

    // BEQ taken, predicted not taken
    set_req(1, 0, 0, 0, 1, 3'd0, 32'h100, 32'd5, 32'd5, 32'h20, 0, 32'h100);
    tick();
    chk("beq_je", bif.je, 1);
    chk("beq_target", bif.target, 32'h120);
    chk("beq_link", bif.link, 32'h104);
    chk("beq_misp", bif.mispredict, 1);
    idle(32'h100); #1 chk("beq_ctr_10", bif.lookup_taken, 1);
    tick();

    // BLT vs BLTU on the same operands
    set_req(1, 0, 0, 0, 1, 3'd4, 32'h200, 32'hFFFF_FFFF, 32'd1, 32'h8, 0, 32'h0);
    tick();
    chk("blt_je", bif.je, 1);
    set_req(1, 0, 0, 0, 1, 3'd6, 32'h200, 32'hFFFF_FFFF, 32'd1, 32'h8, 0, 32'h0);
    tick();
    chk("bltu_je", bif.je, 0);
    chk("bltu_target", bif.target, 32'h204);

    // JALR clears bit 0, table untouched
    set_req(1, 0, 1, 1, 0, 3'd0, 32'h300, 32'h1001, 32'h0, 32'h10, 1, 32'h300);
    tick();
    chk("jalr_target", bif.target, 32'h1010);
    chk("jalr_misp", bif.mispredict, 0);

    // Four taken branches at 0x40 with same-cycle lookup, then decay
    for (int i = 0; i < 4; i++) begin
      set_req(1, 0, 0, 0, 1, 3'd0, 32'h40, 32'd7, 32'd7, 32'h10, 1, 32'h40);
      #1 chk("bht_same_cycle", bif.lookup_taken, exp_lk[i]);
      tick();
    end
    for (int i = 0; i < 2; i++) begin
      set_req(1, 0, 0, 0, 1, 3'd1, 32'h40, 32'd7, 32'd7, 32'h10, 0, 32'h40);
      #1 chk("bht_decay", bif.lookup_taken, 1);
      tick();
    end
    idle(32'h40); #1 chk("bht_after_decay", bif.lookup_taken, 0);
    tick();

    // Flush with and without a request
    set_req(1, 1, 0, 0, 1, 3'd0, 32'h40, 32'd1, 32'd1, 32'h10, 0, 32'h40);
    tick();
    chk("flush_valid", bif.out_valid, 0);
    set_req(0, 1, 0, 0, 0, 3'd0, 32'h40, 32'd1, 32'd1, 32'h10, 0, 32'h40);
    tick();

    // Reset mid-stream
    set_req(1, 0, 1, 0, 0, 3'd0, 32'h500, 32'h0, 32'h0, 32'h40, 0, 32'h40);
    do_reset();
    tick();
    set_req(1, 0, 0, 0, 1, 3'd0, 32'h100, 32'd3, 32'd3, 32'h20, 0, 32'h100);
    tick();
    idle(32'h100); #1 chk("post_rst_ctr_10", bif.lookup_taken, 1);
    tick();

    // Perf counters: 3 branches (1 mispredicted) + 1 mispredicted jump
    do_reset();
    set_req(1, 0, 0, 0, 1, 3'd0, 32'h80, 32'd2, 32'd2, 32'h8, 1, 32'h0); tick();
    set_req(1, 0, 0, 0, 1, 3'd1, 32'h84, 32'd2, 32'd2, 32'h8, 0, 32'h0); tick();
    set_req(1, 0, 0, 0, 1, 3'd0, 32'h88, 32'd2, 32'd2, 32'h8, 0, 32'h0); tick();
    set_req(1, 0, 1, 0, 0, 3'd0, 32'h8C, 32'd0, 32'd0, 32'h8, 0, 32'h0); tick();
    idle(32'h0); tick();
`ifdef BRU_PERF_CNT_EN
    chk("perf_br_total", bif.perf_branches, 3);
    chk("perf_mp_total", bif.perf_mispredicts, 2);
`else
    chk("perf_br_off", bif.perf_branches, 0);
    chk("perf_mp_off", bif.perf_mispredicts, 0);
`endif

    // Random traffic
    for (int n = 0; n < 400; n++) begin
      pc = ($urandom_range(0, 31) << 2) | (($urandom_range(0, 3) == 0) ? $urandom : 32'h0);
      a  = ($urandom_range(0, 3) == 0) ? 32'h8000_0000 : $urandom;
      b  = ($urandom_range(0, 2) == 0) ? a : $urandom;
      set_req($urandom_range(0, 3) != 0, $urandom_range(0, 7) == 0, $urandom_range(0, 4) == 0,
              $urandom_range(0, 1) == 1, $urandom_range(0, 3) != 0, 3'($urandom_range(0, 7)),
              pc, a, b, $urandom, $urandom_range(0, 1) == 1,
              ($urandom_range(0, 1) == 1) ? pc : ($urandom_range(0, 31) << 2));
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
